// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the command record used by the initiator and its bench.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb_stall_timer.sv
// Saturating stall counter with a sticky limit flag; setting the flag outranks clearing it.
module ahb_stall_timer #(
  parameter int unsigned         CNT_W = 16,
  parameter logic [CNT_W-1:0]    LIMIT = CNT_W'(1024)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_i,
  input  logic clr_i,
  output logic err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             hit;

  // A LIMIT of zero leaves the counter parked at zero and never sets the flag.
  always_comb begin
    cnt_d = '0;
    if (stall_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign hit = (LIMIT != '0) && (cnt_d == LIMIT);

  always_comb begin
    err_d = err_q;
    if (hit) begin
      err_d = 1'b1;
    end else if (clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready command stream to pipelined NONSEQ word transfers,
// completions returned on a one-cycle response strobe.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA
);

  htrans_t           htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic adv, dp_enter, rsp_fire, stall;

  assign adv      = (htrans_q == HTRANS_IDLE) || HREADY;
  assign dp_enter = HREADY && (htrans_q == HTRANS_NONSEQ);
  assign rsp_fire = dp_valid_q && HREADY;
  assign stall    = dp_valid_q && !HREADY;

  always_comb begin
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    ap_wdata_d = ap_wdata_q;
    if (adv) begin
      if (cmd_valid) begin
        htrans_d   = HTRANS_NONSEQ;
        haddr_d    = cmd_addr;
        hwrite_d   = cmd_write;
        ap_wdata_d = cmd_wdata;
      end else begin
        htrans_d = HTRANS_IDLE;
      end
    end
  end

  // Entry taking priority over retire gives the same-edge hand-over between transfers.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    hwdata_d   = hwdata_q;
    if (dp_enter) begin
      dp_valid_d = 1'b1;
      dp_write_d = hwrite_q;
      hwdata_d   = ap_wdata_q;
    end else if (HREADY) begin
      dp_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_fire;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_fire) begin
      rsp_write_d = dp_write_q;
      rsp_rdata_d = dp_write_q ? '0 : HRDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  ahb_stall_timer #(
    .CNT_W (16),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .stall_i (stall),
    .clr_i   (err_clr),
    .err_o   (timeout_err)
  );

  assign cmd_ready = adv;
  assign HTRANS    = htrans_q;
  assign HSEL      = (htrans_q == HTRANS_NONSEQ);
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = hwdata_q;
  assign busy      = (htrans_q != HTRANS_IDLE) || dp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Scoreboard bench: memory-backed slave with programmable wait states, reference memory model.
`timescale 1ns/1ps
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

  localparam int TO = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, err_clr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write, busy, timeout_err;
  logic [31:0] rsp_rdata;
  logic        HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16'd8)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA)
  );

  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
  } rsp_t;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  rsp_t        rsp_q[$];
  ahb_cmd_t    bus_q[$];
  int          wait_q[$];
  int          rsp_cyc[$];
  int          max_wait = 0;
  int          consec = 0;
  logic        exp_to = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  // Memory slave: decides from the bus what each edge did, then drives HREADY/HRDATA.
  initial begin : slave_model
    logic        dp_act, s_rstn, s_ready, s_write, s_clr, s_hsel;
    logic        p_valid, p_ready, p_write;
    logic [1:0]  s_trans, p_trans;
    logic [2:0]  s_hsize;
    logic [31:0] s_addr, s_wdata, p_addr;
    ahb_cmd_t    dp, e;
    int          wl;
    dp_act = 1'b0; p_valid = 1'b0; wl = 0;
    p_ready = 1'b1; p_write = 1'b0; p_trans = '0; p_addr = '0;
    dp = '0;
    forever begin
      @(negedge HCLK);
      s_rstn = HRESETn; s_ready = HREADY; s_trans = HTRANS; s_addr = HADDR;
      s_write = HWRITE; s_wdata = HWDATA; s_clr = err_clr; s_hsel = HSEL; s_hsize = HSIZE;
      if (s_rstn && p_valid && !p_ready && p_trans == 2'b10)
        chk("ap_hold", {s_trans, s_write, s_addr}, {p_trans, p_write, p_addr});
      p_valid = s_rstn; p_ready = s_ready; p_trans = s_trans; p_addr = s_addr; p_write = s_write;
      @(posedge HCLK);
      #1;
      if (!s_rstn || !HRESETn) begin
        dp_act = 1'b0; wl = 0; consec = 0; exp_to = 1'b0; p_valid = 1'b0;
      end else begin
        if (s_ready) begin
          if (dp_act && dp.write) begin
            chk("hwdata", {32'h0, s_wdata}, {32'h0, dp.wdata});
            mem[s_addr[5:2] & 4'h0 | dp.addr[5:2]] = s_wdata;
          end
          consec = 0;
          dp_act = (s_trans == 2'b10);
          if (dp_act) begin
            chk("hsel_hsize", {s_hsel, s_hsize}, {1'b1, 3'b010});
            if (bus_q.size() == 0) begin
              checks++;
              $display("FAIL bus_unexpected: got addr %0h expected no transfer", s_addr);
              dp = '{write: s_write, addr: s_addr, wdata: 32'h0};
            end else begin
              e = bus_q.pop_front();
              chk("bus_addr", {s_write, s_addr}, {e.write, e.addr});
              dp = '{write: s_write, addr: s_addr, wdata: e.wdata};
            end
            wl = (wait_q.size() != 0) ? wait_q.pop_front() : $urandom_range(0, max_wait);
          end
        end else if (dp_act) begin
          consec++;
          if (wl > 0) wl--;
        end
        if (consec >= TO) exp_to = 1'b1;
        else if (s_clr) exp_to = 1'b0;
      end
      HREADY = !(dp_act && wl > 0);
      HRDATA = (dp_act && !dp.write) ? mem[dp.addr[5:2]] : $urandom;
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (rsp_valid) begin
        rsp_t e;
        rsp_cyc.push_back(cyc);
        if (rsp_q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: got write=%0b rdata=%0h expected none", rsp_write, rsp_rdata);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp", {31'h0, rsp_write, rsp_rdata}, {31'h0, e.write, e.rdata});
        end
      end
      chk("timeout_err", 64'(timeout_err), 64'(exp_to));
    end
  end

  task automatic summary_and_fatal(input string why);
    checks++;
    $display("FAIL %s: got no progress expected completion", why);
    $display("%0d/%0d checks passed", passed, checks);
    $fatal(1);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int stalls, output int acc);
    logic rdy;
    int   n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    forever begin
      @(negedge HCLK);
      rdy = cmd_ready;
      acc = cyc + 1;
      @(posedge HCLK);
      if (rdy) break;
      n++;
      if (n > 200) summary_and_fatal("accept_timeout");
    end
    bus_q.push_back('{write: w, addr: a, wdata: d});
    if (w) begin
      ref_mem[a[5:2]] = d;
      rsp_q.push_back('{write: 1'b1, rdata: 32'h0});
    end else begin
      rsp_q.push_back('{write: 1'b0, rdata: ref_mem[a[5:2]]});
    end
    stalls = n;
    #2;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(posedge HCLK);
    #2;
  endtask

  initial begin : watchdog
    #500000;
    summary_and_fatal("watchdog");
  end

  initial begin : stimulus
    int st, acc, acc0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    repeat (3) @(posedge HCLK);
    #2;
    chk("reset_state", {HTRANS, HWRITE, HSEL, busy, rsp_valid, rsp_write, timeout_err, HADDR, HWDATA},
        {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    chk("reset_rdata", {32'h0, rsp_rdata}, 64'h0);
    @(negedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK);
    #2;

    // Single write, zero wait states.
    rsp_cyc.delete();
    issue(1'b1, 32'h0, 32'h41, st, acc);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("wr_aphase", {HTRANS, HWRITE, busy, HADDR}, {2'b10, 1'b1, 1'b1, 32'h0});
    @(negedge HCLK);
    chk("wr_dphase", {HTRANS, HWDATA}, {2'b00, 32'h41});
    idle(4);
    chk("wr_rsp_count", 64'(rsp_cyc.size()), 64'd1);
    if (rsp_cyc.size() == 1) chk("wr_latency", 64'(rsp_cyc[0] - acc), 64'd2);

    // Single read.
    rsp_cyc.delete();
    issue(1'b0, 32'h10, 32'h0, st, acc);
    idle(5);
    if (rsp_cyc.size() == 1) chk("rd_latency", 64'(rsp_cyc[0] - acc), 64'd2);
    else chk("rd_rsp_count", 64'(rsp_cyc.size()), 64'd1);

    // Four back-to-back writes.
    rsp_cyc.delete();
    acc0 = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'(i * 4), $urandom, st, acc);
      if (i == 0) acc0 = acc;
      chk("b2b_ready", 64'(st), 64'd0);
      chk("b2b_accept_cycle", 64'(acc - acc0), 64'(i));
    end
    idle(6);
    chk("b2b_rsp_count", 64'(rsp_cyc.size()), 64'd4);
    if (rsp_cyc.size() == 4)
      for (int i = 0; i < 4; i++) chk("b2b_rsp_cycle", 64'(rsp_cyc[i] - acc0), 64'(2 + i));

    // Three wait states on the first of a pipelined pair; third command sees the back-pressure.
    rsp_cyc.delete();
    wait_q.push_back(3); wait_q.push_back(0); wait_q.push_back(0);
    issue(1'b0, 32'h10, 32'h0, st, acc0);
    issue(1'b0, 32'h4, 32'h0, st, acc);
    chk("ws_second_accept", 64'(st), 64'd0);
    issue(1'b0, 32'h8, 32'h0, st, acc);
    chk("ws_ready_stall", 64'(st), 64'd3);
    idle(8);
    chk("ws_rsp_count", 64'(rsp_cyc.size()), 64'd3);
    if (rsp_cyc.size() == 3)
      for (int i = 0; i < 3; i++) chk("ws_rsp_cycle", 64'(rsp_cyc[i] - acc0), 64'(5 + i));

    // Long stall: timeout sets, clear during stall loses, clear afterwards wins.
    rsp_cyc.delete();
    wait_q.push_back(20);
    issue(1'b0, 32'h20, 32'h0, st, acc);
    idle(12);
    chk("to_set", 64'(timeout_err), 64'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("to_set_wins", 64'(timeout_err), 64'd1);
    idle(12);
    chk("to_one_rsp", 64'(rsp_cyc.size()), 64'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("to_clr", 64'(timeout_err), 64'd0);

    // Reset during a stalled data phase.
    wait_q.push_back(50);
    issue(1'b0, 32'h24, 32'h0, st, acc);
    idle(4);
    @(negedge HCLK);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_async", {HTRANS, HWRITE, HSEL, busy, rsp_valid, rsp_write, timeout_err, HADDR, HWDATA},
        {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    chk("rst_rdata", {32'h0, rsp_rdata}, 64'h0);
    rsp_q.delete(); bus_q.delete(); wait_q.delete(); rsp_cyc.delete();
    repeat (2) @(negedge HCLK);
    #1 HRESETn = 1'b1;
    idle(4);
    chk("rst_no_rsp", 64'(rsp_cyc.size()), 64'd0);
    issue(1'b1, 32'h28, 32'h1234_5678, st, acc);
    issue(1'b0, 32'h28, 32'h0, st, acc);
    idle(6);
    chk("rst_recover", 64'(rsp_cyc.size()), 64'd2);

    // Randomized traffic with up to three wait states per transfer.
    max_wait = 3;
    for (int i = 0; i < 200; i++) begin
      issue(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, st, acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(20);
    chk("drain_rsp", 64'(rsp_q.size()), 64'd0);
    chk("drain_bus", 64'(bus_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
